// File: rtl/matmul_job_arbiter.sv
// Round-robin owner arbitration for a shared matmul engine,
// with start/done handshake, cycle counting and a watchdog.
module matmul_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] eng_sel,
  output logic             eng_start,
  input  logic             eng_done,
  output logic [NREQ-1:0]  job_done,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] last_cycles
);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t           state, state_n;
  logic [IDX_W-1:0] rr_ptr, ptr_n;
  logic [CNT_W-1:0] cyc_cnt, cnt_n;
  logic [NREQ-1:0]  grant_n, jd_n;
  logic [IDX_W-1:0] sel_n;
  logic [CNT_W-1:0] last_n;
  logic             start_n, to_n;

  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   pos;
  logic             found;
  logic [CNT_W-1:0] cnt_inc;
  logic [IDX_W-1:0] ptr_adv;
  logic             wd_hit;

  // scan from rr_ptr upward, wrapping at NREQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NREQ))
        pos = pos - (IDX_W+1)'(NREQ);
      if (!found && req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = pos[IDX_W-1:0];
      end
    end
  end

  assign cnt_inc = (&cyc_cnt) ? cyc_cnt
                              : cyc_cnt + CNT_W'(1);
  assign ptr_adv = (eng_sel == IDX_W'(NREQ-1)) ? '0
                 : eng_sel + IDX_W'(1);
  assign wd_hit  = (TIMEOUT != 0) && (cyc_cnt == TO_LAST);

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    cnt_n   = cyc_cnt;
    grant_n = grant;
    sel_n   = eng_sel;
    last_n  = last_cycles;
    start_n = 1'b0;
    jd_n    = '0;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = ONE << win;
          sel_n   = win;
          state_n = START;
        end
      end
      START: begin
        start_n = 1'b1;
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        cnt_n = cnt_inc;
        // completion takes priority over the watchdog
        if (eng_done) begin
          jd_n    = ONE << eng_sel;
          last_n  = cnt_inc;
          grant_n = '0;
          ptr_n   = ptr_adv;
          state_n = IDLE;
        end else if (wd_hit) begin
          to_n    = 1'b1;
          grant_n = '0;
          ptr_n   = ptr_adv;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cyc_cnt     <= '0;
      grant       <= '0;
      eng_sel     <= '0;
      eng_start   <= 1'b0;
      job_done    <= '0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      last_cycles <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= ptr_n;
      cyc_cnt     <= cnt_n;
      grant       <= grant_n;
      eng_sel     <= sel_n;
      eng_start   <= start_n;
      job_done    <= jd_n;
      timeout     <= to_n;
      busy        <= (state_n != IDLE);
      last_cycles <= last_n;
    end
  end

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed bench for matmul_job_arbiter: handshake timing,
// round-robin order, watchdog and reset behaviour.
module tb_matmul_job_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [1:0]  eng_sel;
  logic        eng_start;
  logic        eng_done;
  logic [3:0]  job_done;
  logic        timeout;
  logic        busy;
  logic [15:0] last_cycles;

  int n_chk = 0;
  int n_err = 0;

  matmul_job_arbiter #(
    .NREQ(4), .IDX_W(2), .CNT_W(16), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .grant(grant),
    .eng_sel(eng_sel),
    .eng_start(eng_start),
    .eng_done(eng_done),
    .job_done(job_done),
    .timeout(timeout),
    .busy(busy),
    .last_cycles(last_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IDLE until a grant appears; exactly one IDLE cycle expected
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (grant == 4'b0 && n < 50) begin
      step();
      n++;
      if (n == 1)
        check({tag, "_jd_pulse"}, 32'(job_done), 32'h0);
    end
    check({tag, "_idle"}, 32'(n), 32'd1);
  endtask

  task automatic do_job(input string tag, input int idx,
                        input int k, input bit drop,
                        input bit dis);
    logic [3:0] g;
    g = 4'b0001 << idx;
    wait_grant(tag);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_sel"}, 32'(eng_sel), 32'(idx));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_nostart"}, 32'(eng_start), 32'd0);
    if (dis) eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check({tag, "_start"}, 32'(eng_start), 32'd1);
    if (dis)
      check({tag, "_ign"}, 32'(job_done), 32'h0);
    if (drop) req = 4'b0;
    repeat (k - 1) step();
    if (k >= 2)
      check({tag, "_start1"}, 32'(eng_start), 32'd0);
    check({tag, "_hold"}, 32'(grant), 32'(g));
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check({tag, "_jd"}, 32'(job_done), 32'(g));
    check({tag, "_last"}, 32'(last_cycles), 32'(k));
    check({tag, "_noto"}, 32'(timeout), 32'd0);
    check({tag, "_gclr"}, 32'(grant), 32'h0);
    check({tag, "_bclr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0;
    eng_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_last", 32'(last_cycles), 32'd0);
    check("rst_sel", 32'(eng_sel), 32'd0);
    rst_n = 1'b1;
    step();

    req = 4'b0001;
    do_job("single", 0, 5, 1'b0, 1'b0);

    // reset while RUN: outputs clear at once, rr_ptr back to 0
    req = 4'b0100;
    wait_grant("mrst");
    check("mrst_grant", 32'(grant), 32'h4);
    step();
    step();
    #2;
    rst_n = 1'b0;
    req   = 4'b0;
    #1;
    check("mrst_grant0", 32'(grant), 32'h0);
    check("mrst_busy0", 32'(busy), 32'd0);
    check("mrst_last0", 32'(last_cycles), 32'd0);
    check("mrst_sel0", 32'(eng_sel), 32'd0);
    step();
    check("mrst_jd", 32'(job_done), 32'h0);
    check("mrst_to", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    req = 4'b1111;
    for (int j = 0; j < 6; j++)
      do_job($sformatf("rr%0d", j), j % 4, 3, 1'b0, 1'b0);

    // rr_ptr is 2 now: index 0 wins over index 1
    req = 4'b0011;
    do_job("rot0", 0, 2, 1'b0, 1'b0);
    do_job("drop1", 1, 4, 1'b1, 1'b0);

    req = 4'b1100;
    wait_grant("wd");
    check("wd_grant", 32'(grant), 32'h4);
    step();
    check("wd_start", 32'(eng_start), 32'd1);
    repeat (7) step();
    check("wd_early", 32'(timeout), 32'd0);
    check("wd_hold", 32'(grant), 32'h4);
    step();
    check("wd_to", 32'(timeout), 32'd1);
    check("wd_jd", 32'(job_done), 32'h0);
    check("wd_last", 32'(last_cycles), 32'd4);
    check("wd_gclr", 32'(grant), 32'h0);
    check("wd_bclr", 32'(busy), 32'd0);

    // done lands exactly on the watchdog cycle
    do_job("edge", 3, 8, 1'b0, 1'b0);

    req = 4'b0001;
    do_job("dstart", 0, 3, 1'b0, 1'b1);
    req = 4'b0;
    step();
    check("end_jd", 32'(job_done), 32'h0);
    check("end_to", 32'(timeout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_job_arbiter.md
Name: matmul_job_arbiter

Overview:
- Round-robin scheduler that shares one matrix-multiply engine between NREQ requesters.
- Grants the engine to one requester per job, issues the engine start pulse and drives the operand/result mux select.
- Waits for engine done, then returns a per-requester completion pulse and the job's cycle count.
- Includes a watchdog that abandons jobs whose engine never reports done.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDX_W, 2, width of requester index; 2^IDX_W >= NREQ.
- CNT_W, 16, width of job cycle counter.
- TIMEOUT, 1024, max RUN cycles before abandoning a job; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester job request, level.
- grant  out  NREQ  one-hot owner of engine; all-zero when idle.
- eng_sel  out  IDX_W  index of granted requester, for operand/result muxing.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_done  in  1  engine completion, one-cycle pulse.
- job_done  out  NREQ  one-cycle completion pulse to owning requester.
- timeout  out  1  one-cycle pulse when watchdog abandons a job.
- busy  out  1  high in START and RUN.
- last_cycles  out  CNT_W  RUN-cycle count of last completed job.

Behaviour:
- Reset (async, rst_n low): state=IDLE, rr_ptr=0, cyc_cnt=0.
  - All outputs 0: grant, eng_sel, eng_start, job_done, timeout, busy, last_cycles.
  - Reset mid-job abandons it silently with no job_done or timeout; the engine shares rst_n.
- States: IDLE, START, RUN.
- IDLE:
  - If req != 0, the winner is the first set bit scanning from index rr_ptr upward, wrapping at NREQ-1 to 0.
  - Register grant=onehot(winner), eng_sel=winner, go to START.
  - If req == 0, stay in IDLE.
- START (1 cycle):
  - eng_start=1, cyc_cnt<=0, go to RUN.
  - eng_done in START is ignored.
- RUN:
  - eng_start=0; each cycle cyc_cnt<=cyc_cnt+1, saturating at all-ones.
  - If eng_done:
    - job_done[eng_sel]=1 for one cycle.
    - last_cycles<=cyc_cnt+1 (saturating).
    - grant<=0, rr_ptr<=(eng_sel+1) mod NREQ, go to IDLE.
  - Else if TIMEOUT!=0 and cyc_cnt==TIMEOUT-1:
    - timeout=1 for one cycle; job_done not asserted; last_cycles unchanged.
    - grant<=0, rr_ptr advances as on completion, go to IDLE.
  - eng_done and the timeout condition in the same cycle: completion wins, no timeout pulse.
- Latency:
  - req rises before edge E0: grant visible after E0, eng_start high between E1 and E2.
  - Minimum job (eng_done in first RUN cycle) gives last_cycles=1.
- Gaps: at least one IDLE cycle between consecutive jobs; eng_start never asserts on back-to-back cycles.
- Request sampling:
  - req is sampled only in IDLE.
  - A requester dropping req while granted does not abort the job; job_done still pulses.
  - Requesters hold req until job_done. req still high after job_done is treated as a new request at lowest priority for that requester.
- Signal rules:
  - grant stays stable and one-hot for the whole START+RUN interval.
  - eng_sel is held at its last value in IDLE.
  - busy = (state != IDLE).
- req bits at index >= NREQ do not exist; rr_ptr wraps at NREQ, not at 2^IDX_W.
- All outputs registered; no combinational path from req or eng_done to any output.

Test Plan:
- Reset then single request:
  - Stimulus: req=0001, engine returns eng_done 5 cycles after eng_start.
  - Required: grant=0001 one cycle after req, eng_start a single pulse, job_done=0001 one pulse, last_cycles=5, busy drops the same cycle grant clears.
- Round-robin fairness:
  - Stimulus: req=1111 held continuously, each job 3 cycles.
  - Required: grant order 0001,0010,0100,1000,0001; last_cycles=3 every job; exactly one IDLE cycle between jobs.
- Priority rotation with gaps:
  - Stimulus: rr_ptr=2 (after serving index 1), req=0011.
  - Required: index 0 granted before index 1.
- Watchdog:
  - Stimulus: TIMEOUT=8, engine never asserts done.
  - Required: timeout pulses on the 8th RUN cycle, job_done stays 0, last_cycles keeps its previous value, next requester is granted afterwards.
- Boundary cases:
  - eng_done on the exact cycle cyc_cnt==TIMEOUT-1 -> job_done pulses, no timeout.
  - eng_done asserted during START -> ignored; the job completes only on a later RUN-cycle done.
- Mid-operation events:
  - Requester drops req during RUN -> job_done still pulses for it.
  - rst_n pulsed low in RUN -> outputs 0 immediately, no job_done or timeout, rr_ptr=0 afterwards.
